// File: rtl/track_pkg.sv
// Shared types and constants for the single-track section arbiter.
// Holds the FSM state encoding, side identifiers, default timeouts and small helpers.
package track_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ROUTE    = 3'd1,
      ST_GRANT    = 3'd2,
      ST_OCCUPIED = 3'd3,
      ST_GUARD    = 3'd4,
      ST_FAULT    = 3'd5
   } arb_state_t;

   localparam logic SIDE0 = 1'b0;
   localparam logic SIDE1 = 1'b1;

   localparam int DEF_SW_TIMEOUT    = 16;
   localparam int DEF_GRANT_TIMEOUT = 64;
   localparam int DEF_GUARD_CYCLES  = 8;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // One-hot signal aspect for the given side.
   function automatic logic [1:0] green_for(input logic side);
      return (side == SIDE1) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/track_arbiter_if.sv
// Train-side bundle of the section arbiter: requests, sensors and switch feedback in,
// signal aspects, switch command and status out.
interface track_arbiter_if;
   logic [1:0] req;
   logic [1:0] entry;
   logic       exit_sens;
   logic       sw_fb;
   logic       fault_clr;
   logic [1:0] green;
   logic       sw_cmd;
   logic       owner;
   logic       busy;
   logic       fault;

   modport master (
      output req, entry, exit_sens, sw_fb, fault_clr,
      input  green, sw_cmd, owner, busy, fault
   );

   modport slave (
      input  req, entry, exit_sens, sw_fb, fault_clr,
      output green, sw_cmd, owner, busy, fault
   );
endinterface

// File: rtl/section_timer.sv
// Shared down-counter for the arbiter: load wins over enable, saturates at zero.
// expired flags the last enabled cycle (count==1).
module section_timer #(
   parameter int W = 7
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         expired
);
   logic [W-1:0] count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (en && (count_reg != '0)) begin
         count_reg <= count_reg - W'(1);
      end
   end

   assign count   = count_reg;
   assign expired = en && (count_reg == W'(1));
endmodule

// File: rtl/track_arbiter.sv
// Single-track section arbiter: round-robin grant between two trains, switch routing
// with confirmation, occupancy tracking and a latched safety fault.
module track_arbiter
   import track_pkg::*;
#(
   parameter int SW_TIMEOUT    = DEF_SW_TIMEOUT,
   parameter int GRANT_TIMEOUT = DEF_GRANT_TIMEOUT,
   parameter int GUARD_CYCLES  = DEF_GUARD_CYCLES
) (
   input  logic           clk,
   input  logic           rst_n,
   track_arbiter_if.slave bus
);
   localparam int TW = $clog2(max3(SW_TIMEOUT, GRANT_TIMEOUT, GUARD_CYCLES) + 1);

   arb_state_t state_reg, state_next;
   logic [1:0] green_reg, green_next;
   logic       sw_cmd_reg, sw_cmd_next;
   logic       owner_reg, owner_next;
   logic       busy_reg, busy_next;
   logic       fault_reg, fault_next;
   logic       last_owner_reg, last_owner_next;

   logic          tmr_load, tmr_en, tmr_expired, tmr_done;
   logic [TW-1:0] tmr_val, tmr_count;
   logic          winner, safety_fault, to_fault;

   section_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .en       (tmr_en),
      .count    (tmr_count),
      .expired  (tmr_expired)
   );

   // A zero count can never be loaded, but treating it as expiry keeps the FSM from stalling.
   assign tmr_done     = tmr_expired || (tmr_count == '0);
   assign safety_fault = (bus.sw_fb != sw_cmd_reg) || bus.entry[~owner_reg];

   always_comb begin
      unique case (bus.req)
         2'b01:   winner = SIDE0;
         2'b10:   winner = SIDE1;
         default: winner = ~last_owner_reg;
      endcase
   end

   always_comb begin
      state_next      = state_reg;
      green_next      = green_reg;
      sw_cmd_next     = sw_cmd_reg;
      owner_next      = owner_reg;
      busy_next       = busy_reg;
      fault_next      = fault_reg;
      last_owner_next = last_owner_reg;
      tmr_load        = 1'b0;
      tmr_val         = '0;
      tmr_en          = 1'b0;
      to_fault        = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (bus.req != 2'b00) begin
               state_next  = ST_ROUTE;
               owner_next  = winner;
               sw_cmd_next = winner;
               busy_next   = 1'b1;
               tmr_load    = 1'b1;
               tmr_val     = TW'(SW_TIMEOUT);
            end
         end
         ST_ROUTE: begin
            tmr_en = 1'b1;
            if (bus.sw_fb == sw_cmd_reg) begin
               state_next = ST_GRANT;
               green_next = green_for(owner_reg);
               tmr_load   = 1'b1;
               tmr_val    = TW'(GRANT_TIMEOUT);
            end else if (tmr_done) begin
               to_fault = 1'b1;
            end
         end
         ST_GRANT: begin
            tmr_en = 1'b1;
            if (safety_fault) begin
               to_fault = 1'b1;
            end else if (bus.entry[owner_reg]) begin
               state_next = ST_OCCUPIED;
               green_next = 2'b00;
            end else if (!bus.req[owner_reg] || tmr_done) begin
               state_next = ST_GUARD;
               green_next = 2'b00;
               tmr_load   = 1'b1;
               tmr_val    = TW'(GUARD_CYCLES);
            end
         end
         ST_OCCUPIED: begin
            if (safety_fault) begin
               to_fault = 1'b1;
            end else if (bus.exit_sens) begin
               state_next = ST_GUARD;
               tmr_load   = 1'b1;
               tmr_val    = TW'(GUARD_CYCLES);
            end
         end
         ST_GUARD: begin
            tmr_en = 1'b1;
            if (safety_fault) begin
               to_fault = 1'b1;
            end else if (tmr_done) begin
               state_next      = ST_IDLE;
               busy_next       = 1'b0;
               last_owner_next = owner_reg;
            end
         end
         ST_FAULT: begin
            if (bus.fault_clr) begin
               state_next = ST_IDLE;
               fault_next = 1'b0;
               busy_next  = 1'b0;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      // Every fault path drops the signals and latches the section as blocked.
      if (to_fault) begin
         state_next = ST_FAULT;
         green_next = 2'b00;
         fault_next = 1'b1;
         busy_next  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         green_reg      <= 2'b00;
         sw_cmd_reg     <= SIDE0;
         owner_reg      <= SIDE0;
         busy_reg       <= 1'b0;
         fault_reg      <= 1'b0;
         last_owner_reg <= SIDE1;
      end else begin
         state_reg      <= state_next;
         green_reg      <= green_next;
         sw_cmd_reg     <= sw_cmd_next;
         owner_reg      <= owner_next;
         busy_reg       <= busy_next;
         fault_reg      <= fault_next;
         last_owner_reg <= last_owner_next;
      end
   end

   assign bus.green  = green_reg;
   assign bus.sw_cmd = sw_cmd_reg;
   assign bus.owner  = owner_reg;
   assign bus.busy   = busy_reg;
   assign bus.fault  = fault_reg;
endmodule

// File: tb/tb_track_arbiter.sv
// Bench for track_arbiter: directed scenarios plus random traffic, all checked against
// a phase/elapsed-cycle model of the section rules.
module tb_track_arbiter;
   localparam int SW_TO = 16;
   localparam int GR_TO = 64;
   localparam int GD    = 8;
   localparam int P_IDLE = 0, P_ROUTE = 1, P_GRANT = 2, P_OCC = 3, P_GUARD = 4, P_FAULT = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   track_arbiter_if bus();

   track_arbiter #(
      .SW_TIMEOUT    (SW_TO),
      .GRANT_TIMEOUT (GR_TO),
      .GUARD_CYCLES  (GD)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   bit follow = 1'b0;

   // Model: current phase and cycles elapsed in it, plus the visible outputs.
   int         m_phase, m_cnt;
   logic [1:0] m_green;
   logic       m_sw, m_owner, m_busy, m_fault, m_last;

   function automatic logic [5:0] dut_outs();
      return {bus.green, bus.sw_cmd, bus.owner, bus.busy, bus.fault};
   endfunction

   function automatic logic [5:0] model_outs();
      return {m_green, m_sw, m_owner, m_busy, m_fault};
   endfunction

   task automatic model_reset();
      m_phase = P_IDLE; m_cnt = 0; m_green = 2'b00;
      m_sw = 1'b0; m_owner = 1'b0; m_busy = 1'b0; m_fault = 1'b0; m_last = 1'b1;
   endtask

   task automatic enter_fault();
      m_phase = P_FAULT; m_green = 2'b00; m_fault = 1'b1; m_busy = 1'b1;
   endtask

   task automatic model_step();
      bit flt;
      flt = (bus.sw_fb != m_sw) || bus.entry[!m_owner];
      case (m_phase)
         P_IDLE: if (bus.req != 2'b00) begin
            m_owner = (bus.req == 2'b11) ? !m_last : bus.req[1];
            m_sw = m_owner; m_busy = 1'b1; m_phase = P_ROUTE; m_cnt = 0;
         end
         P_ROUTE: begin
            m_cnt++;
            if (bus.sw_fb == m_sw) begin
               m_phase = P_GRANT; m_cnt = 0; m_green = m_owner ? 2'b10 : 2'b01;
            end else if (m_cnt == SW_TO) enter_fault();
         end
         P_GRANT: begin
            m_cnt++;
            if (flt) enter_fault();
            else if (bus.entry[m_owner]) begin m_phase = P_OCC; m_green = 2'b00; end
            else if (!bus.req[m_owner] || m_cnt == GR_TO) begin
               m_phase = P_GUARD; m_green = 2'b00; m_cnt = 0;
            end
         end
         P_OCC: begin
            if (flt) enter_fault();
            else if (bus.exit_sens) begin m_phase = P_GUARD; m_cnt = 0; end
         end
         P_GUARD: begin
            m_cnt++;
            if (flt) enter_fault();
            else if (m_cnt == GD) begin m_phase = P_IDLE; m_busy = 1'b0; m_last = m_owner; end
         end
         default: if (bus.fault_clr) begin m_phase = P_IDLE; m_fault = 1'b0; m_busy = 1'b0; end
      endcase
   endtask

   // One clock: model follows the edge, the switch feedback trails sw_cmd by one cycle.
   task automatic tick();
      logic prev_sw;
      prev_sw = m_sw;
      @(posedge clk);
      model_step();
      cyc++;
      #1;
      if (follow) bus.sw_fb = prev_sw;
   endtask

   task automatic clear_inputs();
      bus.req = 2'b00; bus.entry = 2'b00; bus.exit_sens = 1'b0; bus.fault_clr = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      bus.sw_fb = 1'b0;
      model_reset();
      #3;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      bus.sw_fb = 1'b0;
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (dut_outs() !== 6'b000000) begin
         errors++; $display("FAIL reset_values: got %b want 000000", dut_outs());
      end
      bus.req = 2'b01;
      @(posedge clk); #1;
      checks++;
      if (dut_outs() !== 6'b000000) begin
         errors++; $display("FAIL reset_hold: got %b want 000000", dut_outs());
      end
      clear_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      $display("reset: outputs cleared and held");
   endtask

   task automatic test_basic_grant();
      int lat, n;
      do_reset(); follow = 1'b1; bus.req = 2'b01; lat = 0;
      while (lat < 10 && bus.green == 2'b00) begin
         tick(); lat++;
         checks++;
         if (dut_outs() !== model_outs()) begin
            errors++; $display("FAIL basic_wait cycle %0d: got %b want %b", cyc, dut_outs(), model_outs());
         end
      end
      checks++;
      if (bus.green !== 2'b01 || lat != 2) begin
         errors++; $display("FAIL basic_latency: green=%b after %0d edges, want 01 after 2", bus.green, lat);
      end
      bus.entry = 2'b01; tick(); bus.entry = 2'b00;
      checks++;
      if (dut_outs() !== model_outs() || bus.green !== 2'b00) begin
         errors++; $display("FAIL basic_entry: got %b want %b", dut_outs(), model_outs());
      end
      bus.req = 2'b00; bus.exit_sens = 1'b1; tick(); bus.exit_sens = 1'b0;
      checks++;
      if (dut_outs() !== model_outs()) begin
         errors++; $display("FAIL basic_exit: got %b want %b", dut_outs(), model_outs());
      end
      n = 0;
      while (n < 20 && bus.busy) begin
         tick(); n++;
         checks++;
         if (dut_outs() !== model_outs()) begin
            errors++; $display("FAIL basic_guard cycle %0d: got %b want %b", cyc, dut_outs(), model_outs());
         end
      end
      checks++;
      if (n != GD) begin
         errors++; $display("FAIL basic_guard_len: got %0d cycles want %0d", n, GD);
      end
      $display("basic grant: latency %0d edges, guard %0d cycles", lat, n);
   endtask

   task automatic test_round_robin();
      int n;
      logic exp_side;
      do_reset(); follow = 1'b1; bus.req = 2'b11;
      for (int g = 0; g < 4; g++) begin
         exp_side = g[0];
         n = 0;
         while (n < 40 && bus.green == 2'b00) begin
            tick(); n++;
            checks++;
            if (dut_outs() !== model_outs()) begin
               errors++; $display("FAIL rr_wait cycle %0d: got %b want %b", cyc, dut_outs(), model_outs());
            end
         end
         checks++;
         if (bus.owner !== exp_side || bus.sw_cmd !== exp_side || bus.green !== (exp_side ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL rr_order grant %0d: owner=%b sw_cmd=%b green=%b want side %0d", g, bus.owner, bus.sw_cmd, bus.green, exp_side);
         end
         $display("round robin: grant %0d to side %0d after %0d edges", g, bus.owner, n);
         bus.entry = exp_side ? 2'b10 : 2'b01; tick(); bus.entry = 2'b00;
         bus.exit_sens = 1'b1; tick(); bus.exit_sens = 1'b0;
         n = 0;
         while (n < 20 && bus.busy) begin
            tick(); n++;
            checks++;
            if (dut_outs() !== model_outs()) begin
               errors++; $display("FAIL rr_release cycle %0d: got %b want %b", cyc, dut_outs(), model_outs());
            end
         end
      end
      bus.req = 2'b00;
   endtask

   task automatic test_switch_fault();
      int n;
      do_reset(); follow = 1'b0; bus.sw_fb = 1'b0; bus.req = 2'b10; n = 0;
      while (n < 40 && !bus.fault) begin
         tick(); n++;
         checks++;
         if (dut_outs() !== model_outs() || bus.green !== 2'b00) begin
            errors++; $display("FAIL sw_wait cycle %0d: got %b want %b", cyc, dut_outs(), model_outs());
         end
      end
      checks++;
      if (n != SW_TO + 1) begin
         errors++; $display("FAIL sw_timeout: fault after %0d edges, want %0d", n, SW_TO + 1);
      end
      bus.req = 2'b00; bus.fault_clr = 1'b1; tick(); bus.fault_clr = 1'b0;
      checks++;
      if (bus.fault !== 1'b0 || bus.busy !== 1'b0 || bus.sw_cmd !== 1'b1 || dut_outs() !== model_outs()) begin
         errors++; $display("FAIL fault_clear: got %b want %b", dut_outs(), model_outs());
      end
      follow = 1'b1; tick();
      $display("switch fault: raised after %0d edges, cleared", n);
   endtask

   task automatic test_intrusion();
      int n;
      do_reset(); follow = 1'b1; bus.req = 2'b01; n = 0;
      while (n < 10 && bus.green == 2'b00) begin tick(); n++; end
      bus.entry = 2'b01; tick();
      checks++;
      if (dut_outs() !== model_outs()) begin
         errors++; $display("FAIL intr_occupy: got %b want %b", dut_outs(), model_outs());
      end
      bus.entry = 2'b10; tick();
      checks++;
      if (bus.fault !== 1'b1 || bus.green !== 2'b00 || bus.sw_cmd !== 1'b0 || bus.busy !== 1'b1) begin
         errors++; $display("FAIL intrusion: got %b want 000011", dut_outs());
      end
      clear_inputs(); bus.fault_clr = 1'b1; tick(); bus.fault_clr = 1'b0;
      checks++;
      if (dut_outs() !== model_outs()) begin
         errors++; $display("FAIL intr_clear: got %b want %b", dut_outs(), model_outs());
      end
      $display("intrusion: fault latched from OCCUPIED and cleared");
   endtask

   task automatic test_withdraw_timeout();
      int n;
      do_reset(); follow = 1'b1; bus.req = 2'b01; n = 0;
      while (n < 10 && bus.green == 2'b00) begin tick(); n++; end
      bus.req = 2'b00; tick();
      checks++;
      if (bus.green !== 2'b00 || bus.busy !== 1'b1 || dut_outs() !== model_outs()) begin
         errors++; $display("FAIL withdraw: got %b want %b", dut_outs(), model_outs());
      end
      n = 0;
      while (n < 20 && bus.busy) begin tick(); n++; end
      bus.req = 2'b01; n = 0;
      while (n < 10 && bus.green == 2'b00) begin tick(); n++; end
      n = 0;
      while (n < 100 && bus.green != 2'b00) begin
         tick(); n++;
         checks++;
         if (dut_outs() !== model_outs()) begin
            errors++; $display("FAIL grant_hold cycle %0d: got %b want %b", cyc, dut_outs(), model_outs());
         end
      end
      checks++;
      if (n != GR_TO) begin
         errors++; $display("FAIL grant_timeout: green for %0d cycles want %0d", n, GR_TO);
      end
      bus.req = 2'b00; n = 0;
      while (n < 20 && bus.busy) begin tick(); n++; end
      $display("withdraw/timeout: green held %0d cycles without entry", GR_TO);
   endtask

   task automatic test_async_reset();
      int n;
      do_reset(); follow = 1'b1; bus.req = 2'b01; n = 0;
      while (n < 10 && bus.green == 2'b00) begin tick(); n++; end
      bus.entry = 2'b01; tick(); bus.entry = 2'b00;
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (dut_outs() !== 6'b000000) begin
         errors++; $display("FAIL async_reset: got %b want 000000", dut_outs());
      end
      bus.req = 2'b10;
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      while (n < 10 && bus.green == 2'b00) begin tick(); n++; end
      checks++;
      if (bus.owner !== 1'b1 || bus.green !== 2'b10 || dut_outs() !== model_outs()) begin
         errors++; $display("FAIL post_reset_grant: got %b want %b", dut_outs(), model_outs());
      end
      bus.req = 2'b00;
      $display("async reset: cleared mid-occupancy, side 1 granted after %0d edges", n);
   endtask

   task automatic test_random();
      logic [1:0] prev_green;
      do_reset(); follow = 1'b1; prev_green = 2'b00;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 7) == 0) bus.req = 2'($urandom_range(0, 3));
         bus.entry = 2'b00;
         if (m_phase == P_GRANT && $urandom_range(0, 3) == 0) bus.entry[m_owner] = 1'b1;
         if ($urandom_range(0, 199) == 0) bus.entry[!m_owner] = 1'b1;
         bus.exit_sens = ($urandom_range(0, 5) == 0);
         bus.fault_clr = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 199) == 0) bus.sw_fb = !bus.sw_fb;
         tick();
         checks++;
         if (dut_outs() !== model_outs()) begin
            errors++; $display("FAIL random cycle %0d: got %b want %b", cyc, dut_outs(), model_outs());
         end
         if (prev_green == 2'b00 && m_green != 2'b00)
            $display("random: grant to side %0d at cycle %0d", m_owner, cyc);
         prev_green = m_green;
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      bus.sw_fb = 1'b0;
      model_reset();
      test_reset();
      test_basic_grant();
      test_round_robin();
      test_switch_fault();
      test_intrusion();
      test_withdraw_timeout();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule
